// File: rtl/tube_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller: four time slots, each driving
// one right-bank and one left-bank digit, with a double-buffered frame update path.
module tube_scan_ctrl #(
    parameter int DIV_CYCLES   = 10000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_on,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_blank,
    input  logic [7:0]  upd_dp,
    output logic [7:0]  tube_r,
    output logic [7:0]  tube_l,
    output logic [7:0]  tube_en,
    output logic        frame_tick
);

    localparam int MAX_CYCLES = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // Segment pattern a..g,dp for one hex nibble; a blanked digit suppresses dp too.
    function automatic logic [7:0] seg_decode_f(input logic [3:0] nib,
                                                input logic       dp,
                                                input logic       blank);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hFC;
            4'h1:    seg = 8'h60;
            4'h2:    seg = 8'hDA;
            4'h3:    seg = 8'hF2;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'hB6;
            4'h6:    seg = 8'hBE;
            4'h7:    seg = 8'hE0;
            4'h8:    seg = 8'hFE;
            4'h9:    seg = 8'hF6;
            4'hA:    seg = 8'hEE;
            4'hB:    seg = 8'h3E;
            4'hC:    seg = 8'h9C;
            4'hD:    seg = 8'h7A;
            4'hE:    seg = 8'h9E;
            4'hF:    seg = 8'h8E;
            default: seg = 8'h00;
        endcase
        if (blank) begin
            return 8'h00;
        end else begin
            return seg | {7'b000_0000, dp};
        end
    endfunction

    logic [0:0]       state_r, state_s;
    logic [1:0]       slot_r, slot_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic             shadow_full_r, shadow_full_s;
    logic [31:0]      shadow_data_r;
    logic [7:0]       shadow_blank_r;
    logic [7:0]       shadow_dp_r;
    logic [31:0]      active_data_r;
    logic [7:0]       active_blank_r;
    logic [7:0]       active_dp_r;

    logic [7:0]       tube_r_r, tube_l_r, tube_en_r;
    logic             frame_tick_r, upd_ready_r;

    logic             xfer_s, commit_pt_s, commit_s;
    logic [2:0]       dig_r_idx_s, dig_l_idx_s;
    logic [3:0]       nib_r_s, nib_l_s;
    logic [7:0]       seg_r_s, seg_l_s;
    logic [7:0]       tube_r_s, tube_l_s, tube_en_s;

    // Slot sequencer: dwell counter restarts at every BLANK/SHOW transition.
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_SHOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DIV_LAST) begin
                    state_s = ST_BLANK;
                    slot_s  = slot_r + 2'd1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                slot_s  = 2'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Handshake and frame-end commit; a transfer only happens with the shadow empty,
    // so it can never coincide with a commit of that same shadow.
    always_comb begin
        xfer_s      = upd_valid & upd_ready_r;
        commit_pt_s = (state_r == ST_SHOW) && (slot_r == 2'd3) && (cnt_r == DIV_LAST);
        commit_s    = commit_pt_s & shadow_full_r;
        if (xfer_s) begin
            shadow_full_s = 1'b1;
        end else if (commit_s) begin
            shadow_full_s = 1'b0;
        end else begin
            shadow_full_s = shadow_full_r;
        end
    end

    // Output image for the upcoming cycle, derived from next-state so registered
    // outputs line up with the sequencer state they belong to.
    always_comb begin
        dig_r_idx_s = {1'b0, slot_s};
        dig_l_idx_s = {1'b1, slot_s};
        nib_r_s     = active_data_r[{dig_r_idx_s, 2'b00} +: 4];
        nib_l_s     = active_data_r[{dig_l_idx_s, 2'b00} +: 4];
        seg_r_s     = seg_decode_f(nib_r_s, active_dp_r[dig_r_idx_s], active_blank_r[dig_r_idx_s]);
        seg_l_s     = seg_decode_f(nib_l_s, active_dp_r[dig_l_idx_s], active_blank_r[dig_l_idx_s]);
        tube_en_s   = 8'h00;
        if (state_s == ST_SHOW) begin
            tube_r_s = seg_r_s;
            tube_l_s = seg_l_s;
            // Blanked digits keep their enable low so an all-blank display stays dark.
            if (disp_on) begin
                tube_en_s[dig_r_idx_s] = ~active_blank_r[dig_r_idx_s];
                tube_en_s[dig_l_idx_s] = ~active_blank_r[dig_l_idx_s];
            end else begin
                tube_en_s = 8'h00;
            end
        end else begin
            tube_r_s = 8'h00;
            tube_l_s = 8'h00;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BLANK;
            slot_r  <= 2'd0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            cnt_r   <= cnt_s;
        end
    end

    // Shadow and active display buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_full_r  <= 1'b0;
            shadow_data_r  <= 32'h0000_0000;
            shadow_blank_r <= 8'h00;
            shadow_dp_r    <= 8'h00;
            active_data_r  <= 32'h0000_0000;
            active_blank_r <= 8'hFF;
            active_dp_r    <= 8'h00;
        end else begin
            shadow_full_r <= shadow_full_s;
            if (xfer_s) begin
                shadow_data_r  <= upd_data;
                shadow_blank_r <= upd_blank;
                shadow_dp_r    <= upd_dp;
            end
            if (commit_s) begin
                active_data_r  <= shadow_data_r;
                active_blank_r <= shadow_blank_r;
                active_dp_r    <= shadow_dp_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tube_r_r     <= 8'h00;
            tube_l_r     <= 8'h00;
            tube_en_r    <= 8'h00;
            frame_tick_r <= 1'b0;
            upd_ready_r  <= 1'b1;
        end else begin
            tube_r_r     <= tube_r_s;
            tube_l_r     <= tube_l_s;
            tube_en_r    <= tube_en_s;
            frame_tick_r <= commit_pt_s;
            upd_ready_r  <= ~shadow_full_s;
        end
    end

    assign tube_r     = tube_r_r;
    assign tube_l     = tube_l_r;
    assign tube_en    = tube_en_r;
    assign frame_tick = frame_tick_r;
    assign upd_ready  = upd_ready_r;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Directed, table-driven bench for tube_scan_ctrl with DIV_CYCLES=4, BLANK_CYCLES=2
// (24-cycle frame): update, ignored update, commit-point update, disp_on and reset.
module tb_tube_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        disp_on;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_data;
    logic [7:0]  upd_blank;
    logic [7:0]  upd_dp;
    logic [7:0]  tube_r;
    logic [7:0]  tube_l;
    logic [7:0]  tube_en;
    logic        frame_tick;

    tube_scan_ctrl #(
        .DIV_CYCLES  (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_on   (disp_on),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_data  (upd_data),
        .upd_blank (upd_blank),
        .upd_dp    (upd_dp),
        .tube_r    (tube_r),
        .tube_l    (tube_l),
        .tube_en   (tube_en),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ph;
        int         cyc;
        logic [7:0] en;
        logic [7:0] r;
        logic [7:0] l;
        logic       tick;
        logic       rdy;
    } vec_t;

    vec_t vecs[64];
    int   n_vecs;
    int   n_applied;
    int   n_miscompares;

    task automatic add(input int ph, input int cyc, input logic [7:0] en,
                       input logic [7:0] r, input logic [7:0] l,
                       input logic tick, input logic rdy);
        vecs[n_vecs] = '{ph: ph, cyc: cyc, en: en, r: r, l: l, tick: tick, rdy: rdy};
        n_vecs++;
    endtask

    task automatic check_cycle(input int ph, input int cyc);
        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].ph == ph && vecs[i].cyc == cyc) begin
                n_applied++;
                if (tube_en !== vecs[i].en || tube_r !== vecs[i].r || tube_l !== vecs[i].l ||
                    frame_tick !== vecs[i].tick || upd_ready !== vecs[i].rdy) begin
                    n_miscompares++;
                    $display("FAIL ph%0d_cyc%0d: got en=%h r=%h l=%h tick=%b rdy=%b, want en=%h r=%h l=%h tick=%b rdy=%b",
                             ph, cyc, tube_en, tube_r, tube_l, frame_tick, upd_ready,
                             vecs[i].en, vecs[i].r, vecs[i].l, vecs[i].tick, vecs[i].rdy);
                end
            end
        end
    endtask

    // Inputs for the cycle about to be clocked; valid and rst are single-cycle.
    task automatic drive(input int ph, input int cyc);
        rst       = 1'b0;
        upd_valid = 1'b0;
        if (ph == 0) begin
            case (cyc)
                0: begin
                    upd_valid = 1'b1; upd_data = 32'h7654_3210;
                    upd_blank = 8'h00; upd_dp = 8'h01;
                end
                5, 6: begin
                    upd_valid = 1'b1; upd_data = 32'hFFFF_FFFF;
                    upd_blank = 8'h00; upd_dp = 8'hFF;
                end
                47: begin
                    upd_valid = 1'b1; upd_data = 32'hFEDC_BA98;
                    upd_blank = 8'h20; upd_dp = 8'h80;
                end
                57: disp_on = 1'b0;
                58: disp_on = 1'b1;
                96: begin
                    upd_valid = 1'b1; upd_data = 32'h1111_1111;
                    upd_blank = 8'h00; upd_dp = 8'h00;
                end
                110: rst = 1'b1;
                default: ;
            endcase
        end
    endtask

    initial begin
        n_vecs        = 0;
        n_applied     = 0;
        n_miscompares = 0;
        rst           = 1'b1;
        disp_on       = 1'b1;
        upd_valid     = 1'b0;
        upd_data      = 32'h0;
        upd_blank     = 8'h00;
        upd_dp        = 8'h00;

        // Phase 0: frame 1 blank, data1 in frames 2-3, data2 (committed late) in frame 4
        add(0,   0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(0,   1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0,   2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0,   7, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0,  20, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0,  23, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0,  24, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        add(0,  25, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(0,  26, 8'h11, 8'hFD, 8'h66, 1'b0, 1'b1);
        add(0,  29, 8'h11, 8'hFD, 8'h66, 1'b0, 1'b1);
        add(0,  30, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(0,  38, 8'h44, 8'hDA, 8'hBE, 1'b0, 1'b1);
        add(0,  44, 8'h88, 8'hF2, 8'hE0, 1'b0, 1'b1);
        add(0,  47, 8'h88, 8'hF2, 8'hE0, 1'b0, 1'b1);
        add(0,  48, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        add(0,  50, 8'h11, 8'hFD, 8'h66, 1'b0, 1'b0);
        add(0,  57, 8'h22, 8'h60, 8'hB6, 1'b0, 1'b0);
        add(0,  58, 8'h00, 8'h60, 8'hB6, 1'b0, 1'b0);
        add(0,  59, 8'h22, 8'h60, 8'hB6, 1'b0, 1'b0);
        add(0,  68, 8'h88, 8'hF2, 8'hE0, 1'b0, 1'b0);
        add(0,  71, 8'h88, 8'hF2, 8'hE0, 1'b0, 1'b0);
        add(0,  72, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        add(0,  74, 8'h11, 8'hFE, 8'h9C, 1'b0, 1'b1);
        add(0,  80, 8'h02, 8'hF6, 8'h00, 1'b0, 1'b1);
        add(0,  86, 8'h44, 8'hEE, 8'h9E, 1'b0, 1'b1);
        add(0,  95, 8'h88, 8'h3E, 8'h8F, 1'b0, 1'b1);
        add(0,  96, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        add(0,  97, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(0, 104, 8'h02, 8'hF6, 8'h00, 1'b0, 1'b0);
        add(0, 110, 8'h44, 8'hEE, 8'h9E, 1'b0, 1'b0);
        // Phase 1: after a reset in slot 2 SHOW with the shadow full
        add(1,   0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,   2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  14, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  23, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  24, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        add(1,  25, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  26, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  47, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        add(1,  48, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c <= ((ph == 0) ? 110 : 48); c++) begin
                check_cycle(ph, c);
                drive(ph, c);
                @(posedge clk);
                #1;
            end
        end

        n_applied++;
        if (n_applied - 1 != n_vecs) begin
            n_miscompares++;
            $display("FAIL table_coverage: applied %0d vectors, table holds %0d", n_applied - 1, n_vecs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/tube_scan_ctrl.md
TUBE_SCAN_CTRL -- requirements
Module: tube_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 10000: SHOW dwell per scan slot in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 200: anti-ghost blank time before each SHOW; legal range >= 1.
REQ-003 SHALL have port clk  input  1  pixel-domain clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port disp_on  input  1  1 = drive digits; 0 = force all enables low while scanning continues.
REQ-006 SHALL have port upd_valid  input  1  frame-update request.
REQ-007 SHALL have port upd_ready  output  1  shadow buffer empty; update can be accepted.
REQ-008 SHALL have port upd_data  input  32  eight hex nibbles; digit k = bits [4k+3:4k].
REQ-009 SHALL have port upd_blank  input  8  per-digit blank; 1 = segments and dp off.
REQ-010 SHALL have port upd_dp  input  8  per-digit decimal point.
REQ-011 SHALL have port tube_r  output  8  segments for digits 0-3; bit7..0 = a,b,c,d,e,f,g,dp; active-high.
REQ-012 SHALL have port tube_l  output  8  segments for digits 4-7; same encoding.
REQ-013 SHALL have port tube_en  output  8  digit enables, active-high.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse at end of each frame.

Function
REQ-015 SHALL scan 4 slots, s = 0..3; slot s drives digit s on tube_r and digit s+4 on tube_l.
REQ-016 SHALL run FSM BLANK -> SHOW -> (slot+1 mod 4) BLANK; BLANK lasts exactly BLANK_CYCLES cycles, SHOW exactly DIV_CYCLES; frame = 4*(BLANK_CYCLES+DIV_CYCLES) cycles.
REQ-017 In BLANK: tube_en = 0, tube_l = tube_r = 0.
REQ-018 In SHOW with disp_on = 1: tube_en = bits s and s+4 set, all others 0; segments = decode of active digit. With disp_on = 0: tube_en = 0; segments still decoded.
REQ-019 Decode table 0..F: FC,60,DA,F2,66,B6,BE,E0,FE,F6,EE,3E,9C,7A,9E,8E (hex), OR'd with dp in bit0; blanked digit = 0x00 regardless of dp.
REQ-020 Outputs SHALL be registered and change only on clk edges; no combinational path from any input to any output.
REQ-021 Handshake: transfer when upd_valid & upd_ready at a rising edge; data/blank/dp copied into shadow; upd_ready goes 0 the next cycle.
REQ-022 Commit: on the last SHOW cycle of slot 3, if the shadow is full, copy shadow to active and mark it empty; upd_ready returns 1 the cycle after; new content is first visible in slot 0 SHOW of the next frame.
REQ-023 frame_tick SHALL pulse high for exactly one cycle, the cycle after the last SHOW cycle of slot 3, every frame, independent of commit.
REQ-024 Simultaneous transfer and commit point: commit uses shadow state before the write; because the shadow was empty (ready = 1), no commit that frame; the accepted data commits at the end of the following frame.
REQ-025 upd_valid while upd_ready = 0 SHALL be ignored; shadow unchanged; no data loss is tracked.
REQ-026 The dwell counter SHALL be sized to hold max(DIV_CYCLES, BLANK_CYCLES)-1 and wrap to 0 at each state change.
REQ-027 disp_on changes SHALL take effect on tube_en the cycle after they are sampled, without disturbing slot timing.

Reset
REQ-028 While rst = 1 at an edge: FSM = BLANK, slot = 0, counter = 0, shadow empty, active data = 0, active blank = 8'hFF, active dp = 0.
REQ-029 Outputs after reset: tube_en = 0, tube_l = 0, tube_r = 0, frame_tick = 0, upd_ready = 1.
REQ-030 Reset asserted mid-frame or mid-handshake SHALL discard shadow and active contents and restart at slot 0 BLANK on the first cycle after rst deasserts.

Verification (DIV_CYCLES=4, BLANK_CYCLES=2, frame = 24 cycles)
REQ-031 Reset release, no update -> tube_en stays 0 for all slots (all blank); frame_tick every 24 cycles; first pulse 24 cycles after release.
REQ-032 Update data 32'h7654_3210, blank 0, dp 8'h01 at cycle 0 -> upd_ready low until commit; next frame slot 0 SHOW: tube_en = 8'h11, tube_r = 8'hFD, tube_l = 8'h66; slot 3: tube_en = 8'h88, tube_r = 8'hF2, tube_l = 8'hE0.
REQ-033 upd_valid held high on the commit-point cycle with ready = 1 -> accepted; that frame's content is unchanged; new content appears one frame later.
REQ-034 Second upd_valid while ready = 0 -> ignored; displayed content equals the first update.
REQ-035 disp_on = 0 during SHOW -> tube_en = 0 from the next cycle; slot and frame_tick timing are unchanged; tube_en restores on re-enable.
REQ-036 rst pulsed mid-SHOW of slot 2 with the shadow full -> outputs go to 0 and upd_ready = 1 after reset; the display stays blank until a new update commits.
